multicycle_ctrl: RTL

Multi-cycle sequencing controller for the RV32I core. It decodes the 7-bit opcode and steps the shared datapath (PC, instruction register, ALU, register file, unified memory port) through fetch/decode/execute/memory/writeback states, one state per clock. It handles a valid/ready handshake on the memory port, traps on illegal opcodes or memory timeout, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Sequencing controller for the multi-cycle RV32I core. Walks the shared
// datapath through fetch/decode/execute/memory/writeback, one state per
// clock. It handshakes on the unified memory port, traps on illegal opcodes
// or a stalled memory, and counts retired instructions.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   opcode[6:0]           instruction[6:0], looked at in DECODE only
//   zero                  ALU zero flag, looked at in BRANCH
//   mem_ready             memory completes the current request this cycle
//   mem_req, mem_we, iord memory request, write qualifier, address select
//   ir_write, pc_write    IR / PC load enables
//   pc_src                PC source (0=ALU result, 1=ALUOut)
//   alu_src_a/b, alu_op   ALU operand selects and operation class
//   reg_write, mem_to_reg register file write enable and writeback source
//   trap, trap_cause      sticky trap flag and first cause (1=opcode, 2=timeout)
//   instret[31:0]         retired-instruction counter
//   state[3:0]            current state, for debug
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        EXEC_R    = 4'd3,
        EXEC_I    = 4'd4,
        MEM_ADDR  = 4'd5,
        MEM_READ  = 4'd6,
        MEM_WRITE = 4'd7,
        MEM_WB    = 4'd8,
        ALU_WB    = 4'd9,
        BRANCH    = 4'd10,
        TRAP      = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int CW = $clog2(MEM_TIMEOUT) + 1;
    // Count value seen in the last stalled cycle that is still tolerated.
    localparam logic [CW-1:0] WAIT_LAST = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

    state_t        cur_state;
    state_t        next_state;
    logic [CW-1:0] wait_cnt;
    logic          is_load;
    logic          waiting;
    logic          timeout;
    logic          retire;
    logic [1:0]    next_cause;

    assign state = cur_state;

    // A memory-facing state is "waiting" when it requests but memory has not
    // answered; timeout fires on the last tolerated stalled cycle. A ready in
    // that same cycle wins because waiting already requires mem_ready low.
    assign waiting = ((cur_state == FETCH) || (cur_state == MEM_READ) ||
                      (cur_state == MEM_WRITE)) && !mem_ready;
    assign timeout = waiting && (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    // Next-state and control decode. Everything defaults to 0 so each state
    // only lists the outputs it actually drives. pc_write/ir_write are gated
    // by mem_ready (FETCH) and zero (BRANCH) combinationally.
    always_comb begin
        next_state = cur_state;
        next_cause = 2'd0;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (cur_state)
            IDLE: next_state = FETCH;
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    next_state = DECODE;
                end else if (timeout) begin
                    next_state = TRAP;
                    next_cause = 2'd2;
                end
            end
            DECODE: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                case (opcode)
                    OP_R:              next_state = EXEC_R;
                    OP_I:              next_state = EXEC_I;
                    OP_LOAD, OP_STORE: next_state = MEM_ADDR;
                    OP_BRANCH:         next_state = BRANCH;
                    default: begin
                        next_state = TRAP;
                        next_cause = 2'd1;
                    end
                endcase
            end
            EXEC_R: begin
                alu_src_a  = 2'd1;
                alu_op     = 2'b10;
                next_state = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                alu_op     = 2'b11;
                next_state = ALU_WB;
            end
            MEM_ADDR: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                next_state = is_load ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    next_state = MEM_WB;
                end else if (timeout) begin
                    next_state = TRAP;
                    next_cause = 2'd2;
                end
            end
            MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    next_state = FETCH;
                    retire     = 1'b1;
                end else if (timeout) begin
                    next_state = TRAP;
                    next_cause = 2'd2;
                end
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            ALU_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 2'd1;
                alu_op     = 2'b01;
                pc_src     = 1'b1;
                pc_write   = zero;
                retire     = 1'b1;
                next_state = FETCH;
            end
            TRAP: next_state = TRAP;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Stall counter: counts stalled cycles while a request is outstanding and
    // falls back to 0 otherwise, so it is always 0 on entry to a memory state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (waiting && !timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Remember in DECODE whether this is a load, since the opcode input is
    // not trusted again by the time MEM_ADDR picks read versus write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_load <= 1'b0;
        end else if (cur_state == DECODE) begin
            is_load <= (opcode == OP_LOAD);
        end
    end

    // Sticky trap flag and cause, captured on the edge that enters TRAP.
    // Only the first cause is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap       <= 1'b0;
            trap_cause <= 2'd0;
        end else if ((next_state == TRAP) && (cur_state != TRAP)) begin
            trap <= 1'b1;
            if (trap_cause == 2'd0) begin
                trap_cause <= next_cause;
            end
        end
    end

    // Retired-instruction counter; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= 32'd0;
        end else if (retire) begin
            instret <= instret + 32'd1;
        end
    end

endmodule
